// File: rtl/rd53_pix_pkg.sv
// Shared types and constants for the RD53 pixel ToT counter and its hit FIFO.
package rd53_pix_pkg;

    localparam int TOT_W_DFLT  = 4;
    localparam int BCID_W_DFLT = 8;
    localparam int DROP_CNT_W  = 8;

    typedef enum logic [1:0] {
        WAIT_LOW,
        IDLE,
        COUNT
    } tot_state_e;

    typedef struct packed {
        logic [TOT_W_DFLT-1:0]  tot;
        logic [BCID_W_DFLT-1:0] bcid;
    } hit_word_t;

endpackage

// File: rtl/rd53_hit_fifo.sv
// DEPTH-entry synchronous FIFO of hit words with a registered head word,
// registered valid/full flags and a synchronous clear that beats push and pop.
module rd53_hit_fifo
    import rd53_pix_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      clear,
    input  logic      push,
    input  hit_word_t push_word,
    input  logic      pop,
    output logic      valid,
    output logic      full,
    output hit_word_t head
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]    ONE_C   = (AW+1)'(1);

    hit_word_t         mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     rd_next;
    logic [AW:0]       count_q, count_d;
    hit_word_t         head_q, head_d;
    logic              valid_q, valid_d;
    logic              full_q, full_d;
    logic              do_push, do_pop;

    // NOTE: every signal gets a default at the top of the block, so no path
    // through it leaves a value unassigned and no latch is inferred.
    always_comb begin
        do_pop   = pop & valid_q & ~clear;
        do_push  = push & (~full_q | do_pop) & ~clear;
        rd_next  = rd_ptr_q + 1'b1;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            head_d   = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            // The head register is loaded from the entry behind the one being
            // popped, or straight from the incoming word when that entry is new.
            if (do_pop) begin
                rd_ptr_d = rd_next;
                if (count_q > ONE_C) begin
                    head_d = mem_q[rd_next];
                end else if (do_push) begin
                    head_d = push_word;
                end
            end else if (do_push && !valid_q) begin
                head_d = push_word;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        valid_d = (count_d != '0);
        full_d  = (count_d == DEPTH_C);
    end

    // NOTE: the storage array carries no reset; occupancy and pointers do, so
    // stale contents are never presented as valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
        end
    end

    assign valid = valid_q;
    assign full  = full_q;
    assign head  = head_q;

endmodule

// File: rtl/rd53_pixel_tot_counter.sv
// Per-pixel hit processor: synchronises HIT, measures ToT, tags the leading-edge
// BCID and queues the resulting words for the region readout.
module rd53_pixel_tot_counter
    import rd53_pix_pkg::*;
#(
    parameter int TOT_W       = TOT_W_DFLT,
    parameter int BCID_W      = BCID_W_DFLT,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST_B,
    input  logic                  HIT,
    input  logic                  ENABLE,
    input  logic                  CLEAR,
    input  logic [BCID_W-1:0]     BCID,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [TOT_W-1:0]      OUT_TOT,
    output logic [BCID_W-1:0]     OUT_BCID,
    output logic                  OVERFLOW,
    output logic [DROP_CNT_W-1:0] DROP_CNT,
    output logic                  HIT_OR
);

    localparam logic [TOT_W-1:0] TOT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] prime_q, prime_d;
    logic                   hs, hs_d_q, primed;
    logic                   hit_or_q, hit_or_d;
    tot_state_e             state_q, state_d;
    logic [TOT_W-1:0]       tot_q, tot_d;
    logic [BCID_W-1:0]      bcid_q, bcid_d;
    logic                   push;
    logic                   drop;
    logic                   overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic                   fifo_valid, fifo_full, fifo_pop;
    hit_word_t              push_word, head_word;

    // prime_q marks when the chain holds real HIT samples rather than reset
    // zeros, so a HIT already high at reset release is not mistaken for low.
    assign sync_d  = {sync_q[SYNC_STAGES-2:0], HIT};
    assign prime_d = {prime_q[SYNC_STAGES-2:0], 1'b1};
    assign hs      = sync_q[SYNC_STAGES-1];
    assign primed  = prime_q[SYNC_STAGES-1];
    assign hit_or_d = hs & ENABLE;

    always_comb begin
        state_d = state_q;
        tot_d   = tot_q;
        bcid_d  = bcid_q;
        push    = 1'b0;

        if (CLEAR) begin
            state_d = WAIT_LOW;
            tot_d   = '0;
            bcid_d  = '0;
        end else begin
            unique case (state_q)
                WAIT_LOW: begin
                    if (primed && !hs) begin
                        state_d = IDLE;
                    end
                end
                IDLE: begin
                    if (hs && !hs_d_q && ENABLE) begin
                        state_d = COUNT;
                        bcid_d  = BCID;
                        tot_d   = TOT_W'(1);
                    end
                end
                COUNT: begin
                    // Masking aborts the measurement; a still-high line must
                    // fall before another hit can be accepted.
                    if (!ENABLE) begin
                        state_d = hs ? WAIT_LOW : IDLE;
                    end else if (hs) begin
                        if (tot_q != TOT_MAX) begin
                            tot_d = tot_q + 1'b1;
                        end
                    end else begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = WAIT_LOW;
            endcase
        end
    end

    assign fifo_pop  = fifo_valid & OUT_READY;
    assign drop      = push & fifo_full & ~fifo_pop;
    assign push_word = '{tot: tot_q, bcid: bcid_q};

    always_comb begin
        overflow_d = drop & ~CLEAR;
        drop_cnt_d = drop_cnt_q;
        if (CLEAR) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            sync_q     <= '0;
            prime_q    <= '0;
            hs_d_q     <= 1'b0;
            hit_or_q   <= 1'b0;
            state_q    <= WAIT_LOW;
            tot_q      <= '0;
            bcid_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            sync_q     <= sync_d;
            prime_q    <= prime_d;
            hs_d_q     <= hs;
            hit_or_q   <= hit_or_d;
            state_q    <= state_d;
            tot_q      <= tot_d;
            bcid_q     <= bcid_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    rd53_hit_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RST_B),
        .clear     (CLEAR),
        .push      (push),
        .push_word (push_word),
        .pop       (fifo_pop),
        .valid     (fifo_valid),
        .full      (fifo_full),
        .head      (head_word)
    );

    assign OUT_VALID = fifo_valid;
    assign OUT_TOT   = head_word.tot;
    assign OUT_BCID  = head_word.bcid;
    assign OVERFLOW  = overflow_q;
    assign DROP_CNT  = drop_cnt_q;
    assign HIT_OR    = hit_or_q;

endmodule

// File: tb/tb_rd53_pixel_tot_counter.sv
// Randomised and directed bench for rd53_pixel_tot_counter against a
// run-length / queue reference model of the pixel behaviour.
module tb_rd53_pixel_tot_counter;

    localparam int SYNC    = 2;
    localparam int DEPTH   = 4;
    localparam int TOT_CAP = 15;

    logic       CLK = 1'b0;
    logic       RST_B, HIT, ENABLE, CLEAR, OUT_READY;
    logic [7:0] BCID;
    logic       OUT_VALID, OVERFLOW, HIT_OR;
    logic [3:0] OUT_TOT;
    logic [7:0] OUT_BCID, DROP_CNT;

    rd53_pixel_tot_counter dut (
        .CLK       (CLK),
        .RST_B     (RST_B),
        .HIT       (HIT),
        .ENABLE    (ENABLE),
        .CLEAR     (CLEAR),
        .BCID      (BCID),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_TOT   (OUT_TOT),
        .OUT_BCID  (OUT_BCID),
        .OVERFLOW  (OVERFLOW),
        .DROP_CNT  (DROP_CNT),
        .HIT_OR    (HIT_OR)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: hs is HIT seen through a pure delay line; a word is a
    // qualified run of hs-high cycles, queued with drop-on-full semantics.
    typedef struct { int tot; int bc; } word_t;
    word_t mq[$];
    bit    hq[$];
    bit    m_hs, m_hs_d, m_armed, m_in_run, m_ovf, m_hit_or;
    int    m_edges, m_run, m_bc, m_drops;

    bit       g_hit, g_en, g_clr, g_rdy;
    bit [7:0] g_bc;
    int       ovf_seen;

    task automatic model_reset();
        mq.delete();
        hq.delete();
        for (int i = 0; i < SYNC; i++) hq.push_back(1'b0);
        m_hs = 0; m_hs_d = 0; m_armed = 0; m_in_run = 0; m_ovf = 0; m_hit_or = 0;
        m_edges = 0; m_run = 0; m_bc = 0; m_drops = 0;
    endtask

    task automatic model_step();
        bit    pop, push;
        int    size0;
        word_t w;
        size0 = mq.size();
        pop   = (size0 > 0) && OUT_READY;
        push  = 0;
        w     = '{0, 0};
        if (CLEAR) begin
            mq.delete();
            m_drops = 0; m_ovf = 0; m_armed = 0; m_in_run = 0;
        end else begin
            if (m_in_run) begin
                if (!ENABLE) m_in_run = 0;
                else if (m_hs) m_run++;
                else begin
                    push = 1;
                    w.tot = (m_run > TOT_CAP) ? TOT_CAP : m_run;
                    w.bc = m_bc;
                    m_in_run = 0;
                end
            end else if (m_armed && m_hs && !m_hs_d && ENABLE) begin
                m_in_run = 1; m_run = 1; m_bc = int'(BCID);
            end
            if (m_edges >= SYNC && !m_hs) m_armed = 1;
            m_ovf = 0;
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (size0 < DEPTH || pop) mq.push_back(w);
                else begin
                    m_ovf = 1;
                    if (m_drops < 255) m_drops++;
                end
            end
        end
        m_hit_or = m_hs & ENABLE;
        m_hs_d   = m_hs;
        hq.push_back(HIT);
        void'(hq.pop_front());
        m_hs = hq[0];
        m_edges++;
    endtask

    task automatic compare_all();
        check("valid", OUT_VALID, mq.size() > 0);
        if (mq.size() > 0) begin
            check("head_tot", OUT_TOT, mq[0].tot);
            check("head_bcid", OUT_BCID, mq[0].bc);
        end
        check("overflow", OVERFLOW, m_ovf);
        check("drop_cnt", DROP_CNT, m_drops);
        check("hit_or", HIT_OR, m_hit_or);
        if (OVERFLOW === 1'b1) ovf_seen++;
    endtask

    // One clock: drive at the falling edge, step the model on the rising
    // edge, compare at the next falling edge.
    task automatic cyc();
        HIT = g_hit; ENABLE = g_en; CLEAR = g_clr; OUT_READY = g_rdy; BCID = g_bc;
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        compare_all();
    endtask

    task automatic hit_pulse(input int len);
        g_hit = 1;
        repeat (len) cyc();
        g_hit = 0;
        repeat (SYNC + 3) cyc();
    endtask

    task automatic drain();
        g_rdy = 1;
        repeat (DEPTH + 2) cyc();
        g_rdy = 0;
    endtask

    task automatic do_reset();
        HIT = g_hit; ENABLE = g_en; CLEAR = 0; OUT_READY = g_rdy; BCID = g_bc;
        RST_B = 0;
        #2;
        check("rst_valid", OUT_VALID, 0);
        check("rst_tot", OUT_TOT, 0);
        check("rst_bcid", OUT_BCID, 0);
        check("rst_overflow", OVERFLOW, 0);
        check("rst_drop_cnt", DROP_CNT, 0);
        check("rst_hit_or", HIT_OR, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_B = 1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int n;
        g_hit = 0; g_en = 1; g_clr = 0; g_rdy = 0; g_bc = 8'h00;
        RST_B = 1;
        @(negedge CLK);
        do_reset();
        repeat (5) cyc();

        // Basic 5-cycle hit
        g_bc = 8'h3A;
        hit_pulse(5);
        check("basic_valid", OUT_VALID, 1);
        check("basic_tot", OUT_TOT, 5);
        check("basic_bcid", OUT_BCID, 8'h3A);
        drain();

        // Saturation and single-cycle pulse
        g_bc = 8'h41;
        hit_pulse(20);
        check("sat_tot", OUT_TOT, 15);
        drain();
        hit_pulse(1);
        check("pulse1_tot", OUT_TOT, 1);
        drain();

        // Overflow: five hits into a four-entry FIFO
        ovf_seen = 0;
        for (int i = 0; i < 5; i++) begin
            g_bc = 8'(8'h10 + i);
            hit_pulse(3);
        end
        check("ovf_pulses", ovf_seen, 1);
        check("ovf_drop_cnt", DROP_CNT, 1);
        g_rdy = 1;
        for (int i = 0; i < 4; i++) begin
            check("ovf_order_bcid", OUT_BCID, 8'h10 + i);
            check("ovf_order_tot", OUT_TOT, 3);
            cyc();
        end
        check("ovf_drained", OUT_VALID, 0);
        g_rdy = 0;

        // Full boundary: pop and push in the fall cycle of the fifth hit
        for (int i = 0; i < 4; i++) begin
            g_bc = 8'(8'h20 + i);
            hit_pulse(3);
        end
        ovf_seen = 0;
        g_bc  = 8'h24;
        g_hit = 1;
        repeat (3) cyc();
        g_hit = 0;
        for (int j = 0; j < SYNC + 3; j++) begin
            g_rdy = (j == SYNC);
            cyc();
        end
        check("bnd_no_ovf", ovf_seen, 0);
        check("bnd_drop_cnt", DROP_CNT, 1);
        g_rdy = 1;
        n = 0;
        while (OUT_VALID && n < 8) begin
            check("bnd_bcid", OUT_BCID, 8'h21 + n);
            cyc();
            n++;
        end
        check("bnd_occupancy", n, 4);
        g_rdy = 0;

        // Clear with three words queued
        for (int i = 0; i < 3; i++) begin
            g_bc = 8'(8'h30 + i);
            hit_pulse(2);
        end
        check("clr_pre_valid", OUT_VALID, 1);
        g_clr = 1;
        cyc();
        g_clr = 0;
        check("clr_valid", OUT_VALID, 0);
        check("clr_drop_cnt", DROP_CNT, 0);
        repeat (3) cyc();

        // Masking: enable drops mid-hit and returns while still high
        g_bc  = 8'h55;
        g_hit = 1;
        for (int i = 0; i < 10; i++) begin
            g_en = !(i >= 3 && i < 6);
            cyc();
        end
        g_hit = 0;
        repeat (SYNC + 3) cyc();
        check("mask_no_word", OUT_VALID, 0);
        g_bc = 8'h56;
        hit_pulse(4);
        check("mask_fresh_valid", OUT_VALID, 1);
        check("mask_fresh_tot", OUT_TOT, 4);
        check("mask_fresh_bcid", OUT_BCID, 8'h56);
        drain();

        // HIT held high through reset release
        g_hit = 1;
        do_reset();
        repeat (10) cyc();
        check("rsthi_no_word", OUT_VALID, 0);
        g_hit = 0;
        repeat (SYNC + 2) cyc();
        g_bc = 8'h77;
        hit_pulse(3);
        check("rsthi_valid", OUT_VALID, 1);
        check("rsthi_tot", OUT_TOT, 3);
        drain();

        // Stuck-high line with ENABLE toggling
        g_hit = 1;
        for (int i = 0; i < 40; i++) begin
            g_en = 1'($urandom_range(0, 1));
            cyc();
        end
        check("stuck_no_word", OUT_VALID, 0);
        g_en = 1; g_hit = 0;
        repeat (SYNC + 3) cyc();

        // Randomised traffic
        for (int seg = 0; seg < 400; seg++) begin
            int len;
            g_hit = 1'($urandom_range(0, 1));
            g_en  = ($urandom_range(0, 9) != 0);
            len   = $urandom_range(1, 20);
            for (int k = 0; k < len; k++) begin
                g_rdy = ($urandom_range(0, 2) == 0);
                g_clr = ($urandom_range(0, 199) == 0);
                g_bc  = 8'($urandom);
                cyc();
            end
            g_clr = 0;
            if (seg == 200) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
